// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with frame-error detection
//
// Purpose: receives 8N1 frames from an asynchronous serial line. The line is
// synchronized through two flops, the start bit is qualified at mid-bit, and
// data and stop bits are sampled one bit period apart after that point.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   rx        in   asynchronous serial line, idle high
//   data      out  [7:0] last byte received with a good stop bit
//   new_data  out  one-cycle strobe: data has just been updated
//   frame_err out  one-cycle strobe: stop bit sampled low
//   busy      out  high whenever the receiver is not idle
`timescale 1ns/1ps

module uart_rx_byte #(
  parameter int CLK_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] LP_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;

  logic          r_rx_meta;
  logic          r_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_new_data;
  logic          r_frame_err;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_new_data_nxt;
  logic          w_frame_err_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_new_data  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_new_data  <= w_new_data_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + LP_ONE;
    w_idx_nxt       = r_idx;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    w_new_data_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        // A start bit that is already high again at mid-bit is a glitch.
        if (r_cnt == LP_HALF) begin
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (r_cnt == LP_LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = r_rx_s;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end

      S_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (r_cnt == LP_LAST) begin
          if (r_rx_s) begin
            w_data_nxt     = r_shift;
            w_new_data_nxt = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_WAIT_HI;
          end
        end
      end

      S_WAIT_HI: begin
        // A held-low line (break) must not retrigger a frame.
        w_cnt_nxt = '0;
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end
  end

  assign data      = r_data;
  assign new_data  = r_new_data;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_byte.md
UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 434, giving clk cycles per bit (115200 baud at 50 MHz); legal values are 4 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have port rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-005 The block SHALL have port data, output, 8 bits: the last byte received without error.
REQ-006 The block SHALL have port new_data, output, 1 bit: a one-cycle strobe that data has just been updated.
REQ-007 The block SHALL have port frame_err, output, 1 bit: a one-cycle strobe for a stop bit sampled low.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-009 The block SHALL pass rx through a two-flop synchronizer; both flops reset to 1; all sampling uses the second flop (rx_s).
REQ-010 The frame format SHALL be 8N1: a start bit (0), 8 data bits LSB first, and one stop bit (1).
REQ-011 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HI.
REQ-012 The bit-timing counter SHALL be $clog2(CLK_PER_BIT) bits wide and SHALL clear on every state change.
REQ-013 In IDLE, rx_s==0 SHALL move the FSM to START with the counter at 0.
REQ-014 In START, when the counter reaches CLK_PER_BIT/2-1 (integer division), rx_s SHALL be sampled:
- 0: move to DATA, bit index 0;
- 1: treat as a glitch and return to IDLE with no strobe.
REQ-015 In DATA, each time the counter reaches CLK_PER_BIT-1, rx_s SHALL be shifted into bit position [index] of the internal shift register and the index incremented.
REQ-016 After the sample at index 7, the FSM SHALL move to STOP.
REQ-017 In STOP, when the counter reaches CLK_PER_BIT-1, rx_s SHALL be sampled:
- 1: load data from the shift register, assert new_data for exactly one cycle, go to IDLE;
- 0: assert frame_err for exactly one cycle, leave data unchanged, go to WAIT_HI.
REQ-018 In WAIT_HI, the FSM SHALL stay until rx_s==1, then go to IDLE.
REQ-019 A line held low (break) SHALL produce one frame_err only and no new_data.
REQ-020 new_data and frame_err SHALL never be high in the same cycle and SHALL never be high in consecutive cycles.
REQ-021 Latency: the new_data edge SHALL occur 2 + CLK_PER_BIT/2 + 9*CLK_PER_BIT cycles (±1) after the rx falling edge.
REQ-022 The block SHALL receive back-to-back frames (stop bit followed directly by the next start bit): IDLE is re-entered at mid-stop-bit, so the next falling edge is caught.
REQ-023 data SHALL hold its value until the next good frame; there is no read handshake, and a byte not consumed is overwritten.
REQ-024 Every sample SHALL use the single synchronized value; there is no majority vote.

Reset
REQ-025 When rst_n==0 at a clk edge, the block SHALL set state=IDLE, counter=0, bit index=0, data=8'h00, shift register=8'h00, new_data=0, frame_err=0, busy=0, and both synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-027 After reset releases, the block SHALL ignore the remainder of the aborted frame until rx_s goes high, then go to IDLE; this may cost one frame.

Verification
REQ-028 The bench SHALL cover: CLK_PER_BIT=434, send 0x41 -> data=0x41, one new_data pulse at the REQ-021 cycle, busy low afterwards.
REQ-029 The bench SHALL cover: rx low for 100 cycles, then high -> no new_data or frame_err, busy high then back to 0 inside 220 cycles.
REQ-030 The bench SHALL cover: frame 0x55 with the stop bit driven 0, then line held low for 5 bit times -> one frame_err pulse, data keeps its prior value (0x41), busy stays 1 until rx goes high.
REQ-031 The bench SHALL cover: back-to-back frames 0x00 then 0xFF with no idle gap -> two new_data pulses, data 0x00 then 0xFF.
REQ-032 The bench SHALL cover: rst_n pulsed low during data bit 3 of 0x5A, then a full 0x7E frame -> data=0x00 after reset, then data=0x7E with exactly one new_data.
REQ-033 The bench SHALL cover: sender bit period at 434 ±2% (425 and 443 cycles), send 0xA5 -> data=0xA5 in both cases.
